// File: rtl/nios2_pio_pkg.sv
// Shared constants for the parametrised Nios II PIO slave.
package nios2_pio_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/nios2_pio_sync_edge.sv
// Input synchroniser chain, one-cycle history register and edge detector.
module nios2_pio_sync_edge
  import nios2_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] in_sync,
  output logic [DATA_WIDTH-1:0] edge_pulse
);

  logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev_q <= '0;
    end else begin
      stage[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev_q <= stage[SYNC_STAGES-1];
    end
  end

  assign in_sync = stage[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_q;
  assign fall    = ~in_sync & prev_q;

  // Edge pulse stays combinational so capture lands SYNC_STAGES+1 cycles after the pin.
  assign edge_pulse = (EDGE_TYPE == EDGE_FALL) ? fall :
                      (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) : rise;

endmodule

// File: rtl/nios2_pio_gen.sv
// Avalon-MM PIO slave: data/direction/mask/edge-capture registers, atomic set/clear, irq.
module nios2_pio_gen
  import nios2_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned           EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned           IRQ_TYPE    = IRQ_LEVEL,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  output logic [BUS_W-1:0]      readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] ecap_q;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] ecap_clr;
  logic [BUS_W-1:0]      read_mux;
  logic                  wr_en;
  logic                  rd_en;
  logic                  irq_src;
  logic                  unused_wd_hi;

  nios2_pio_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  assign wr_en        = chipselect & ~write_n;
  assign rd_en        = chipselect & ~read_n;
  assign wd           = writedata[DATA_WIDTH-1:0];
  assign unused_wd_hi = ^writedata;
  assign ecap_clr     = (wr_en && (address == ADDR_EDGECAP)) ? wd : '0;

  assign irq_src = (IRQ_TYPE == IRQ_EDGE) ? |(ecap_q & mask_q)
                                          : |(in_sync & ~dir_q & mask_q);

  // Read mux; write-only and unmapped addresses read as zero.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:    read_mux = BUS_W'((dir_q & data_out) | (~dir_q & in_sync));
      ADDR_DIR:     read_mux = BUS_W'(dir_q);
      ADDR_IRQMASK: read_mux = BUS_W'(mask_q);
      ADDR_EDGECAP: read_mux = BUS_W'(ecap_q);
      default:      read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir_q    <= DIR_RESET;
      mask_q   <= '0;
      ecap_q   <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:     data_out <= wd;
          ADDR_DIR:      dir_q    <= wd;
          ADDR_IRQMASK:  mask_q   <= wd;
          ADDR_OUTSET:   data_out <= data_out | wd;
          ADDR_OUTCLEAR: data_out <= data_out & ~wd;
          default:       ;
        endcase
      end
      // Set dominates clear so a coincident edge is never lost.
      ecap_q <= (ecap_q & ~ecap_clr) | (edge_pulse & ~dir_q);
      irq    <= irq_src;
      if (rd_en) readdata <= read_mux;
    end
  end

  assign out_port = data_out;
  assign oe       = dir_q;

endmodule

// File: tb/tb_nios2_pio_gen.sv
// Randomised + directed bench for nios2_pio_gen; two instances with different edge/irq modes.
module tb_nios2_pio_gen;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1;
  logic [7:0]  out0, out1, oe0, oe1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: rising edge, edge irq, reset value A5. Instance 1: any edge, level irq.
  nios2_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'h00),
                  .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .out_port(out0), .oe(oe0), .irq(irq0));

  nios2_pio_gen #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .DIR_RESET(8'h00),
                  .EDGE_TYPE(2), .IRQ_TYPE(0), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .in_port(in_port), .out_port(out1), .oe(oe1), .irq(irq1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus a history of sampled pin values.
  logic [7:0]  m_data [2];
  logic [7:0]  m_dir  [2];
  logic [7:0]  m_mask [2];
  logic [7:0]  m_ecap [2];
  logic        m_irq  [2];
  logic [31:0] m_rd   [2];
  logic [7:0]  hist [$];

  function automatic int edge_kind(input int m);
    return (m == 0) ? 0 : 2;
  endfunction

  function automatic int irq_kind(input int m);
    return (m == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(8'h00);
    m_data[0] = 8'hA5;
    m_data[1] = 8'h00;
    for (int m = 0; m < 2; m++) begin
      m_dir[m] = 8'h00; m_mask[m] = 8'h00; m_ecap[m] = 8'h00;
      m_irq[m] = 1'b0;  m_rd[m] = 32'h0;
    end
  endtask

  always @(negedge reset_n) model_reset();

  initial begin : model
    logic [7:0] ins, prv, rise, fall, ed, wd8, clr, mux;
    forever begin
      @(posedge clk);
      if (reset_n === 1'b1) begin
        ins  = hist[S-1];
        prv  = hist[S];
        rise = ins & ~prv;
        fall = ~ins & prv;
        wd8  = writedata[7:0];
        for (int m = 0; m < 2; m++) begin
          ed = (edge_kind(m) == 0) ? rise : (edge_kind(m) == 1) ? fall : (rise | fall);
          case (address)
            3'd0:    mux = (m_dir[m] & m_data[m]) | (~m_dir[m] & ins);
            3'd1:    mux = m_dir[m];
            3'd2:    mux = m_mask[m];
            3'd3:    mux = m_ecap[m];
            default: mux = 8'h00;
          endcase
          if (chipselect && !read_n) m_rd[m] = {24'h0, mux};
          m_irq[m] = (irq_kind(m) == 1) ? |(m_ecap[m] & m_mask[m])
                                        : |(ins & ~m_dir[m] & m_mask[m]);
          clr = (chipselect && !write_n && address == 3'd3) ? wd8 : 8'h00;
          m_ecap[m] = (m_ecap[m] & ~clr) | (ed & ~m_dir[m]);
          if (chipselect && !write_n) begin
            case (address)
              3'd0: m_data[m] = wd8;
              3'd1: m_dir[m]  = wd8;
              3'd2: m_mask[m] = wd8;
              3'd4: m_data[m] = m_data[m] | wd8;
              3'd5: m_data[m] = m_data[m] & ~wd8;
              default: ;
            endcase
          end
        end
        hist.push_front(in_port);
        void'(hist.pop_back());
      end
    end
  end

  // Every cycle out of reset, compare all visible outputs with the model.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        check("out0", 32'(out0), 32'(m_data[0]));
        check("out1", 32'(out1), 32'(m_data[1]));
        check("oe0",  32'(oe0),  32'(m_dir[0]));
        check("oe1",  32'(oe1),  32'(m_dir[1]));
        check("irq0", 32'(irq0), 32'(m_irq[0]));
        check("irq1", 32'(irq1), 32'(m_irq[1]));
        check("rd0",  rd0, m_rd[0]);
        check("rd1",  rd1, m_rd[1]);
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    model_reset();
    reset_n = 1'b0; idle(); address = 3'd0; writedata = 32'h0; in_port = 8'h3C;
    cycles(3);
    check("rst_out0", 32'(out0), 32'hA5);
    check("rst_oe0",  32'(oe0),  32'h00);
    check("rst_irq0", 32'(irq0), 32'h0);
    check("rst_rd0",  rd0,       32'h0);
    reset_n = 1'b1;
    cycles(4);

    bus_read(3'd0);
    check("rd_in_3c", rd0, 32'h0000003C);

    bus_write(3'd1, 32'hF0);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd5, 32'h30);
    bus_write(3'd4, 32'h01);
    check("setclr_out", 32'(out0), 32'hCF);
    check("dir_oe", 32'(oe0), 32'hF0);
    in_port = 8'h0A;
    cycles(3);
    bus_read(3'd0);
    check("rd_mixed", rd0, 32'h000000CA);

    // Edge-triggered irq on bit 2 and its clear.
    bus_write(3'd1, 32'h00);
    bus_write(3'd2, 32'h04);
    in_port = 8'h00;
    cycles(4);
    bus_write(3'd3, 32'hFF);
    cycles(1);
    check("irq_idle", 32'(irq0), 32'h0);
    in_port = 8'h04;
    cycles(3);
    check("irq_not_yet", 32'(irq0), 32'h0);
    cycles(1);
    check("irq_set", 32'(irq0), 32'h1);
    bus_read(3'd3);
    check("ecap_bit2", rd0, 32'h04);
    bus_write(3'd3, 32'h04);
    check("irq_hold", 32'(irq0), 32'h1);
    cycles(1);
    check("irq_drop", 32'(irq0), 32'h0);
    bus_read(3'd3);
    check("ecap_clr", rd0, 32'h00);

    // Edge coinciding with a write-1-to-clear of the same bit.
    in_port = 8'h00;
    cycles(4);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h04;
    cycles(2);
    bus_write(3'd3, 32'h04);
    bus_read(3'd3);
    check("edge_wins", rd0, 32'h04);

    // Any-edge capture with bit 0 configured as output.
    bus_write(3'd1, 32'h01);
    in_port = 8'h00;
    cycles(4);
    bus_write(3'd3, 32'hFF);
    in_port = 8'h03;
    cycles(4);
    in_port = 8'h00;
    cycles(4);
    bus_read(3'd3);
    check("any_edge1", rd1, 32'h02);
    check("rise_edge0", rd0, 32'h02);

    // Asynchronous reset in the middle of a write burst with a read pending.
    bus_write(3'd0, 32'h5A);
    bus_write(3'd2, 32'hFF);
    address = 3'd1; writedata = 32'hFF; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_out0", 32'(out0), 32'hA5);
    check("mid_out1", 32'(out1), 32'h00);
    check("mid_oe0",  32'(oe0),  32'h00);
    check("mid_oe1",  32'(oe1),  32'h00);
    check("mid_irq0", 32'(irq0), 32'h0);
    check("mid_irq1", 32'(irq1), 32'h0);
    check("mid_rd0",  rd0,       32'h0);
    check("mid_rd1",  rd1,       32'h0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    cycles(1);
    bus_write(3'd6, 32'hFF);
    bus_read(3'd6);
    check("rd_addr6_0", rd0, 32'h0);
    check("rd_addr6_1", rd1, 32'h0);

    // Random traffic and pin activity, checked cycle by cycle by the monitor.
    for (int i = 0; i < 3000; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      read_n     = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      @(negedge clk);
    end
    idle();
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
